// File: rtl/elbeth_pkg.sv
// rtl/elbeth_pkg.sv - shared constants and next-PC select encoding for the ELBETH fetch PC unit
//
// Contents:
//   XLEN, RESET_VECTOR, EXC_VECTOR, PC_INC, RAS_DEPTH - default configuration
//   pc_sel_e - which source the next PC is taken from
package elbeth_pkg;

    localparam int          XLEN         = 32;
    localparam logic [31:0] RESET_VECTOR = 32'h0000_0200;
    localparam logic [31:0] EXC_VECTOR   = 32'h0000_0100;
    localparam int          PC_INC       = 4;
    localparam int          RAS_DEPTH    = 4;

    typedef enum logic [2:0] {
        SEL_RST,
        SEL_EXC,
        SEL_FLUSH,
        SEL_HOLD,
        SEL_PEND,
        SEL_RAS,
        SEL_SEQ
    } pc_sel_e;

endpackage

// File: rtl/elbeth_ras.sv
// rtl/elbeth_ras.sv - circular return-address stack with saturating occupancy count
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   clear      - drop all entries (exception)
//   push       - write push_addr as the new top entry
//   push_addr  - return address to store
//   pop        - remove the top entry (ignored when empty)
//   top        - current top entry
//   empty      - no entries held (registered)
module elbeth_ras #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            push,
    input  logic [XLEN-1:0] push_addr,
    input  logic            pop,
    output logic [XLEN-1:0] top,
    output logic            empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] mem [DEPTH];
    logic [PW-1:0]   top_ptr;
    logic [CW-1:0]   count;
    logic            pop_ok;
    logic [PW-1:0]   wr_idx;

    assign pop_ok = pop && (count != '0);
    // Push+pop rewrites the current top in place; a plain push advances first.
    // DEPTH is a power of two, so the pointer wraps naturally and a push when
    // full lands on the oldest entry.
    assign wr_idx = pop_ok ? top_ptr : top_ptr + 1'b1;
    assign top    = mem[top_ptr];

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            top_ptr <= '0;
            count   <= '0;
            empty   <= 1'b1;
        end else if (push && pop_ok) begin
            top_ptr <= top_ptr;
            count   <= count;
        end else if (push) begin
            top_ptr <= top_ptr + 1'b1;
            if (count != CW'(DEPTH)) begin
                count <= count + 1'b1;
            end
            empty <= 1'b0;
        end else if (pop_ok) begin
            top_ptr <= top_ptr - 1'b1;
            count   <= count - 1'b1;
            empty   <= (count == CW'(1));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !clear && push) begin
            mem[wr_idx] <= push_addr;
        end
    end

endmodule

// File: rtl/elbeth_pc_unit.sv
// rtl/elbeth_pc_unit.sv - fetch-stage program counter with exception vector, stall-safe redirect and RAS
//
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   ctrl_stall        - hold the PC
//   ctrl_flush        - redirect to flush_target
//   flush_target      - redirect address
//   exc_take          - jump to EXC_VECTOR, drops pending redirect and RAS contents
//   ras_push          - push ras_push_addr onto the RAS
//   ras_push_addr     - return address for a detected call
//   ras_pop           - predicted return, take PC from RAS top
//   pc                - current fetch PC
//   pc_valid          - pc is on the correct path
//   redirect_pending  - a flush arrived during a stall and is waiting
//   ras_empty         - RAS holds no entries
module elbeth_pc_unit #(
    parameter int              XLEN         = elbeth_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(elbeth_pkg::RESET_VECTOR),
    parameter logic [XLEN-1:0] EXC_VECTOR   = XLEN'(elbeth_pkg::EXC_VECTOR),
    parameter int              PC_INC       = elbeth_pkg::PC_INC,
    parameter int              RAS_DEPTH    = elbeth_pkg::RAS_DEPTH
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ctrl_stall,
    input  logic            ctrl_flush,
    input  logic [XLEN-1:0] flush_target,
    input  logic            exc_take,
    input  logic            ras_push,
    input  logic [XLEN-1:0] ras_push_addr,
    input  logic            ras_pop,
    output logic [XLEN-1:0] pc,
    output logic            pc_valid,
    output logic            redirect_pending,
    output logic            ras_empty
);

    import elbeth_pkg::*;

    pc_sel_e         sel;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] pend_target;
    logic [XLEN-1:0] pend_target_next;
    logic            pend_next;
    logic            started;
    logic [XLEN-1:0] ras_top;
    logic            ras_push_eff;
    logic            ras_pop_eff;
    logic            ras_clear;

    // Next-PC source selection, highest priority first.
    always_comb begin
        sel = SEL_SEQ;
        if (rst) begin
            sel = SEL_RST;
        end else if (exc_take) begin
            sel = SEL_EXC;
        end else if (ctrl_flush && !ctrl_stall) begin
            sel = SEL_FLUSH;
        end else if (ctrl_stall) begin
            sel = SEL_HOLD;
        end else if (redirect_pending) begin
            sel = SEL_PEND;
        end else if (!started) begin
            // First cycle out of reset re-presents RESET_VECTOR as a valid fetch.
            sel = SEL_HOLD;
        end else if (ras_pop && !ras_empty) begin
            sel = SEL_RAS;
        end
    end

    always_comb begin
        pc_next          = pc;
        pend_next        = redirect_pending;
        pend_target_next = pend_target;
        unique case (sel)
            SEL_RST: begin
                pc_next          = RESET_VECTOR;
                pend_next        = 1'b0;
                pend_target_next = '0;
            end
            SEL_EXC: begin
                pc_next   = EXC_VECTOR;
                pend_next = 1'b0;
            end
            SEL_FLUSH: begin
                pc_next   = flush_target;
                pend_next = 1'b0;
            end
            SEL_HOLD: begin
                // A flush under stall is remembered; the newest one wins.
                if (ctrl_flush) begin
                    pend_next        = 1'b1;
                    pend_target_next = flush_target;
                end
            end
            SEL_PEND: begin
                pc_next   = pend_target;
                pend_next = 1'b0;
            end
            SEL_RAS: begin
                pc_next = ras_top;
            end
            SEL_SEQ: begin
                pc_next = pc + XLEN'(PC_INC);
            end
            default: begin
                pc_next = pc;
            end
        endcase
    end

    assign ras_push_eff = ras_push && !rst && !exc_take && !ctrl_stall;
    assign ras_pop_eff  = (sel == SEL_RAS);
    assign ras_clear    = exc_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc               <= RESET_VECTOR;
            pc_valid         <= 1'b0;
            redirect_pending <= 1'b0;
            pend_target      <= '0;
            started          <= 1'b0;
        end else begin
            pc               <= pc_next;
            pc_valid         <= !pend_next;
            redirect_pending <= pend_next;
            pend_target      <= pend_target_next;
            started          <= 1'b1;
        end
    end

    elbeth_ras #(
        .XLEN  (XLEN),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .clear     (ras_clear),
        .push      (ras_push_eff),
        .push_addr (ras_push_addr),
        .pop       (ras_pop_eff),
        .top       (ras_top),
        .empty     (ras_empty)
    );

endmodule

// File: tb/tb_elbeth_pc_unit.sv
// tb/tb_elbeth_pc_unit.sv - directed table-driven bench for elbeth_pc_unit
module tb_elbeth_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ctrl_stall = 1'b0;
    logic        ctrl_flush = 1'b0;
    logic [31:0] flush_target = '0;
    logic        exc_take = 1'b0;
    logic        ras_push = 1'b0;
    logic [31:0] ras_push_addr = '0;
    logic        ras_pop = 1'b0;
    logic [31:0] pc;
    logic        pc_valid;
    logic        redirect_pending;
    logic        ras_empty;

    int checks = 0;
    int errors = 0;

    elbeth_pc_unit dut (
        .clk              (clk),
        .rst              (rst),
        .ctrl_stall       (ctrl_stall),
        .ctrl_flush       (ctrl_flush),
        .flush_target     (flush_target),
        .exc_take         (exc_take),
        .ras_push         (ras_push),
        .ras_push_addr    (ras_push_addr),
        .ras_pop          (ras_pop),
        .pc               (pc),
        .pc_valid         (pc_valid),
        .redirect_pending (redirect_pending),
        .ras_empty        (ras_empty)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        flush;
        logic [31:0] tgt;
        logic        exc;
        logic        push;
        logic [31:0] paddr;
        logic        pop;
        logic [31:0] epc;
        logic        ev;
        logic        ep;
        logic        ee;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, input logic s, input logic f, input logic [31:0] t,
                                input logic x, input logic pu, input logic [31:0] pa, input logic po,
                                input logic [31:0] epc, input logic ev, input logic ep, input logic ee);
        vec_t v;
        v.rst = r; v.stall = s; v.flush = f; v.tgt = t; v.exc = x;
        v.push = pu; v.paddr = pa; v.pop = po;
        v.epc = epc; v.ev = ev; v.ep = ep; v.ee = ee;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        rst = v.rst; ctrl_stall = v.stall; ctrl_flush = v.flush; flush_target = v.tgt;
        exc_take = v.exc; ras_push = v.push; ras_push_addr = v.paddr; ras_pop = v.pop;
        @(posedge clk);
        #1;
        chk("pc", idx, pc, v.epc);
        chk("pc_valid", idx, {31'b0, pc_valid}, {31'b0, v.ev});
        chk("redirect_pending", idx, {31'b0, redirect_pending}, {31'b0, v.ep});
        chk("ras_empty", idx, {31'b0, ras_empty}, {31'b0, v.ee});
    endtask

    initial begin
        //                rst st fl tgt            ex pu paddr          po exp_pc         v  p  e
        // reset and free run
        vecs.push_back(mk(1, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_0200, 0, 0, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_0200, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_0200, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_0204, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_0208, 1, 0, 1));
        // flush under a two-cycle stall
        vecs.push_back(mk(0, 1, 1, 32'h1000,       0, 0, 32'h0,         0, 32'h0000_0208, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 32'h1000,       0, 0, 32'h0,         0, 32'h0000_0208, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_1000, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_1004, 1, 0, 1));
        // two flushes in one stall: newest wins
        vecs.push_back(mk(0, 1, 1, 32'h1000,       0, 0, 32'h0,         0, 32'h0000_1004, 0, 1, 1));
        vecs.push_back(mk(0, 1, 1, 32'h2000,       0, 0, 32'h0,         0, 32'h0000_1004, 0, 1, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_2000, 1, 0, 1));
        // flush in release cycle beats pending target
        vecs.push_back(mk(0, 1, 1, 32'h1000,       0, 0, 32'h0,         0, 32'h0000_2000, 0, 1, 1));
        vecs.push_back(mk(0, 0, 1, 32'h3000,       0, 0, 32'h0,         0, 32'h0000_3000, 1, 0, 1));
        // exception over flush, stall and pending; RAS emptied
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 1, 32'h500,       0, 32'h0000_3004, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 32'h4000,       0, 0, 32'h0,         0, 32'h0000_3004, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 32'h5000,       1, 0, 32'h0,         0, 32'h0000_0100, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_0104, 1, 0, 1));
        // push A..E into a 4-deep RAS
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 1, 32'hA00,       0, 32'h0000_0108, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 1, 32'hB00,       0, 32'h0000_010C, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 1, 32'hC00,       0, 32'h0000_0110, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 1, 32'hD00,       0, 32'h0000_0114, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 1, 32'hE00,       0, 32'h0000_0118, 1, 0, 0));
        // pop five times: E, D, C, B, then fall through to pc+4
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h0000_0E00, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h0000_0D00, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h0000_0C00, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h0000_0B00, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h0000_0B04, 1, 0, 1));
        // push+pop in the same cycle replaces the top
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 1, 32'h600,       0, 32'h0000_0B08, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 1, 32'h700,       0, 32'h0000_0B0C, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 1, 32'h800,       1, 32'h0000_0700, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h0000_0800, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h0000_0600, 1, 0, 1));
        // push during stall is dropped; pop on empty falls through
        vecs.push_back(mk(0, 1, 0, 32'h0,          0, 1, 32'h900,       0, 32'h0000_0600, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         1, 32'h0000_0604, 1, 0, 1));
        // address wrap
        vecs.push_back(mk(0, 0, 1, 32'hFFFF_FFFC,  0, 0, 32'h0,         0, 32'hFFFF_FFFC, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_0000, 1, 0, 1));
        // reset while a redirect is pending
        vecs.push_back(mk(0, 1, 1, 32'h1000,       0, 0, 32'h0,         0, 32'h0000_0000, 0, 1, 1));
        vecs.push_back(mk(1, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_0200, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_0200, 1, 0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,          0, 0, 32'h0,         0, 32'h0000_0204, 1, 0, 1));

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Hand sequence: a pending redirect outranks a RAS pop, which is kept for later.
        rst = 0; ctrl_stall = 0; ctrl_flush = 0; exc_take = 0; ras_pop = 0;
        ras_push = 1; ras_push_addr = 32'h0000_8800;
        @(posedge clk); #1;
        chk("seq_push_pc", 100, pc, 32'h0000_0208);
        chk("seq_push_empty", 100, {31'b0, ras_empty}, 32'h0);
        ras_push = 0; ctrl_stall = 1; ctrl_flush = 1; flush_target = 32'h0000_4000;
        @(posedge clk); #1;
        chk("seq_pend", 101, {31'b0, redirect_pending}, 32'h1);
        chk("seq_pend_valid", 101, {31'b0, pc_valid}, 32'h0);
        ctrl_stall = 0; ctrl_flush = 0; ras_pop = 1;
        @(posedge clk); #1;
        chk("seq_pend_beats_pop", 102, pc, 32'h0000_4000);
        chk("seq_ras_kept", 102, {31'b0, ras_empty}, 32'h0);
        @(posedge clk); #1;
        chk("seq_pop_after", 103, pc, 32'h0000_8800);
        chk("seq_pop_empty", 103, {31'b0, ras_empty}, 32'h1);
        ras_pop = 0;
        @(posedge clk); #1;
        chk("seq_seq_after", 104, pc, 32'h0000_8804);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
